// File: rtl/glb_stream_pkg.sv
// rtl/glb_stream_pkg.sv - shared types for the GLB-to-PE stream transmitter
// Contents: stream_sel encodings, transmitter FSM state type, skid FIFO entry layout.
package glb_stream_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int ADDR_BITS_DEF = 16;
  localparam int CNT_BITS_DEF  = 8;
  localparam int XID_BITS_DEF  = 4;
  localparam int YID_BITS_DEF  = 3;

  localparam logic [1:0] STREAM_IFMAP  = 2'd0;
  localparam logic [1:0] STREAM_FILTER = 2'd1;
  localparam logic [1:0] STREAM_IPSUM  = 2'd2;
  localparam logic [1:0] STREAM_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [DATA_SIZE_DEF-1:0] data;
    logic [XID_BITS_DEF-1:0]  tag_x;
    logic [YID_BITS_DEF-1:0]  tag_y;
  } fifo_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry skid FIFO between SRAM read return and the stream port
// Ports: clk, rst_n (async, active-low), flush (drops contents), push/push_data,
//        pop, head_data (oldest entry), full, empty, count (0..2).
module stream_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Push into a full FIFO is legal only together with a pop: the write lands
  // in the slot the pop vacates, because wr_ptr == rd_ptr when full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/glb_pe_stream_tx.sv
// rtl/glb_pe_stream_tx.sv - GLB block reader driving one tagged PE_array input stream per job
// Ports: clk, rst (async, active-low); job inputs start/abort/stream_sel/base_addr/num_rows/
//        num_cols/row_stride/tag_X_base/tag_Y_base; SRAM read port sram_ren/sram_addr/sram_rdata;
//        stream port GLB_{ifmap,filter,ipsum}_valid/ready, GLB_data_in, tag_X, tag_Y; status busy/done.
module glb_pe_stream_tx
  import glb_stream_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF,
  parameter int XID_BITS  = XID_BITS_DEF,
  parameter int YID_BITS  = YID_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           stream_sel,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  num_rows,
  input  logic [CNT_BITS-1:0]  num_cols,
  input  logic [ADDR_BITS-1:0] row_stride,
  input  logic [XID_BITS-1:0]  tag_X_base,
  input  logic [YID_BITS-1:0]  tag_Y_base,
  output logic                 sram_ren,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_SIZE-1:0] sram_rdata,
  output logic                 GLB_ifmap_valid,
  input  logic                 GLB_ifmap_ready,
  output logic                 GLB_filter_valid,
  input  logic                 GLB_filter_ready,
  output logic                 GLB_ipsum_valid,
  input  logic                 GLB_ipsum_ready,
  output logic [DATA_SIZE-1:0] GLB_data_in,
  output logic [XID_BITS-1:0]  tag_X,
  output logic [YID_BITS-1:0]  tag_Y,
  output logic                 busy,
  output logic                 done
);

  tx_state_e            state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [CNT_BITS-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [CNT_BITS-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_BITS-1:0] stride_q, stride_d, row_addr_q, row_addr_d;
  logic [XID_BITS-1:0]  tag_x_base_q, tag_x_base_d, pend_x_q, pend_x_d;
  logic [YID_BITS-1:0]  tag_y_base_q, tag_y_base_d, pend_y_q, pend_y_d;
  logic                 inflight_q, inflight_d;

  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [1:0]  fifo_count;
  fifo_entry_t push_entry, head_entry;
  logic        ready_sel, out_valid, saturated, issue, last_rd;

  stream_skid_fifo #(
    .WIDTH($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    case (sel_q)
      STREAM_IFMAP:  ready_sel = GLB_ifmap_ready;
      STREAM_FILTER: ready_sel = GLB_filter_ready;
      STREAM_IPSUM:  ready_sel = GLB_ipsum_ready;
      default:       ready_sel = 1'b0;
    endcase
    out_valid = !fifo_empty;
    fifo_pop  = out_valid && ready_sel;
    // Buffered words plus the read in flight may not exceed the two FIFO slots;
    // a pop this cycle frees a slot, which is what keeps full-ready at 1 word/cycle.
    saturated = fifo_full || ((fifo_count == 2'd1) && inflight_q);
    issue     = (state_q == ST_RUN) && !abort && (!saturated || fifo_pop);
    last_rd   = (row_q == rows_q - CNT_BITS'(1)) && (col_q == cols_q - CNT_BITS'(1));
    fifo_flush = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // SRAM data returns one cycle after issue, paired with the tags captured then.
    fifo_push        = inflight_q;
    push_entry.data  = sram_rdata;
    push_entry.tag_x = pend_x_q;
    push_entry.tag_y = pend_y_q;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    row_d        = row_q;
    col_d        = col_q;
    stride_d     = stride_q;
    row_addr_d   = row_addr_q;
    tag_x_base_d = tag_x_base_q;
    tag_y_base_d = tag_y_base_q;
    inflight_d   = issue;
    pend_x_d     = issue ? tag_x_base_q + col_q[XID_BITS-1:0] : pend_x_q;
    pend_y_d     = issue ? tag_y_base_q + row_q[YID_BITS-1:0] : pend_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          sel_d        = stream_sel;
          rows_d       = num_rows;
          cols_d       = num_cols;
          stride_d     = row_stride;
          tag_x_base_d = tag_X_base;
          tag_y_base_d = tag_Y_base;
          row_d        = '0;
          col_d        = '0;
          row_addr_d   = base_addr;
          if ((num_rows == '0) || (num_cols == '0) || (stream_sel == STREAM_RSVD)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (issue) begin
          if (last_rd) begin
            state_d = ST_DRAIN;
          end else if (col_q == cols_q - CNT_BITS'(1)) begin
            col_d      = '0;
            row_d      = row_q + CNT_BITS'(1);
            row_addr_d = row_addr_q + stride_q;
          end else begin
            col_d = col_q + CNT_BITS'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fifo_pop && (fifo_count == 2'd1) && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= STREAM_IFMAP;
      rows_q       <= '0;
      cols_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      stride_q     <= '0;
      row_addr_q   <= '0;
      tag_x_base_q <= '0;
      tag_y_base_q <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      row_q        <= row_d;
      col_q        <= col_d;
      stride_q     <= stride_d;
      row_addr_q   <= row_addr_d;
      tag_x_base_q <= tag_x_base_d;
      tag_y_base_q <= tag_y_base_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      inflight_q   <= inflight_d;
    end
  end

  assign sram_ren         = issue;
  assign sram_addr        = issue ? row_addr_q + ADDR_BITS'(col_q) : '0;
  assign GLB_ifmap_valid  = out_valid && (sel_q == STREAM_IFMAP);
  assign GLB_filter_valid = out_valid && (sel_q == STREAM_FILTER);
  assign GLB_ipsum_valid  = out_valid && (sel_q == STREAM_IPSUM);
  assign GLB_data_in      = head_entry.data;
  assign tag_X            = head_entry.tag_x;
  assign tag_Y            = head_entry.tag_y;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_glb_pe_stream_tx.sv
// tb/tb_glb_pe_stream_tx.sv - directed scoreboard bench for glb_pe_stream_tx
module tb_glb_pe_stream_tx;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tx;
    logic [2:0]  ty;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  stream_sel;
  logic [15:0] base_addr, row_stride, sram_addr;
  logic [7:0]  num_rows, num_cols;
  logic [3:0]  tag_X_base, tag_X;
  logic [2:0]  tag_Y_base, tag_Y;
  logic        sram_ren;
  logic [31:0] sram_rdata, GLB_data_in;
  logic        GLB_ifmap_valid, GLB_ifmap_ready;
  logic        GLB_filter_valid, GLB_filter_ready;
  logic        GLB_ipsum_valid, GLB_ipsum_ready;
  logic        busy, done;

  always #5 clk = ~clk;

  glb_pe_stream_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stream_sel(stream_sel),
    .base_addr(base_addr), .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
    .tag_X_base(tag_X_base), .tag_Y_base(tag_Y_base),
    .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .GLB_ifmap_valid(GLB_ifmap_valid), .GLB_ifmap_ready(GLB_ifmap_ready),
    .GLB_filter_valid(GLB_filter_valid), .GLB_filter_ready(GLB_filter_ready),
    .GLB_ipsum_valid(GLB_ipsum_valid), .GLB_ipsum_ready(GLB_ipsum_ready),
    .GLB_data_in(GLB_data_in), .tag_X(tag_X), .tag_Y(tag_Y), .busy(busy), .done(done)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hC0DE, a ^ 16'h5A00};
  endfunction

  // SRAM model: data for the address presented with sram_ren, one cycle later.
  always @(posedge clk) sram_rdata <= sram_ren ? mem_word(sram_addr) : 32'hDEAD_BEEF;

  word_t       exp_word_q[$];
  logic [15:0] exp_addr_q[$];
  logic [3:0]  obs_tx_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int rd_issued = 0, xfers = 0, dropped = 0, ren_cnt = 0;
  int done_cnt = 0, done_cyc = -1, first_xfer_cyc = -1, last_xfer_cyc = -1, start_cyc = 0;
  logic [1:0] exp_sel = 2'd3;
  logic       prev_stall = 1'b0;
  word_t      prev_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0] v, r;
    logic cur_v, cur_r;
    word_t w;
    v = {1'b0, GLB_ipsum_valid, GLB_filter_valid, GLB_ifmap_valid};
    r = {1'b0, GLB_ipsum_ready, GLB_filter_ready, GLB_ifmap_ready};
    for (int i = 0; i < 3; i++) if (2'(i) != exp_sel) chk("unselected_valid_low", v[i], 0);
    cur_v = v[exp_sel];
    cur_r = r[exp_sel];
    w.data = GLB_data_in; w.tx = tag_X; w.ty = tag_Y;
    if (prev_stall) begin
      chk("stall_valid_held", cur_v, 1);
      chk("stall_word_held", w, prev_word);
    end
    if (sram_ren) begin
      rd_issued++; ren_cnt++;
      chk("ren_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) chk("sram_addr", sram_addr, exp_addr_q.pop_front());
    end
    if (cur_v && cur_r) begin
      xfers++;
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      obs_tx_q.push_back(tag_X);
      chk("xfer_expected", exp_word_q.size() != 0, 1);
      if (exp_word_q.size() != 0) chk("xfer_word", w, exp_word_q.pop_front());
    end
    chk("buffered_le_2", (rd_issued - xfers - dropped) <= 2, 1);
    if (done) begin done_cnt++; done_cyc = cyc; end
    prev_stall = cur_v && !cur_r;
    prev_word  = w;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic set_ready(input logic rdy);
    GLB_ifmap_ready  = (exp_sel == 2'd0) ? rdy : !rdy;
    GLB_filter_ready = (exp_sel == 2'd1) ? rdy : !rdy;
    GLB_ipsum_ready  = (exp_sel == 2'd2) ? rdy : !rdy;
  endtask

  task automatic start_job(input logic [1:0] sel, input logic [15:0] base, input int rows,
                           input int cols, input logic [15:0] stride, input logic [3:0] txb,
                           input logic [2:0] tyb);
    word_t w;
    logic [15:0] a;
    stream_sel = sel; base_addr = base; num_rows = 8'(rows); num_cols = 8'(cols);
    row_stride = stride; tag_X_base = txb; tag_Y_base = tyb;
    exp_sel = (rows == 0 || cols == 0) ? 2'd3 : sel;
    if (exp_sel != 2'd3) begin
      for (int rr = 0; rr < rows; rr++) begin
        for (int cc = 0; cc < cols; cc++) begin
          a = base + 16'(rr) * stride + 16'(cc);
          exp_addr_q.push_back(a);
          w.data = mem_word(a); w.tx = txb + 4'(cc); w.ty = tyb + 3'(rr);
          exp_word_q.push_back(w);
        end
      end
    end
    first_xfer_cyc = -1;
    start_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: ready low
  task automatic wait_done(input int budget, input int mode);
    int k = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && k < budget) begin
      set_ready(mode == 0 ? 1'b1 : (mode == 1 ? (k % 3 == 0) : 1'b0));
      step();
      k++;
    end
    chk("done_within_budget", done_cnt != d0, 1);
    step();
    chk("done_single_pulse", done_cnt, d0 + 1);
    chk("addr_queue_drained", exp_addr_q.size(), 0);
    chk("word_queue_drained", exp_word_q.size(), 0);
  endtask

  task automatic drop_job();
    exp_addr_q.delete();
    exp_word_q.delete();
    dropped = rd_issued - xfers;
    prev_stall = 1'b0;
    exp_sel = 2'd3;
  endtask

  initial begin
    int x0, r0, d0;
    logic [3:0] wrap_tx [4];
    wrap_tx[0] = 4'd14; wrap_tx[1] = 4'd15; wrap_tx[2] = 4'd0; wrap_tx[3] = 4'd1;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stream_sel = '0; base_addr = '0;
    num_rows = '0; num_cols = '0; row_stride = '0; tag_X_base = '0; tag_Y_base = '0;
    set_ready(1'b0);
    repeat (3) step();
    chk("rst_sram_ren", sram_ren, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_valids", {GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid}, 0);
    chk("rst_data", GLB_data_in, 0);
    chk("rst_tags", {tag_X, tag_Y}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rst = 1'b1;
    step();

    // ifmap 2x3, full ready: six back-to-back transfers, done one cycle after the last
    set_ready(1'b1);
    exp_sel = 2'd0;
    start_job(2'd0, 16'h0010, 2, 3, 16'd8, 4'd1, 3'd2);
    chk("busy_after_start", busy, 1);
    wait_done(40, 0);
    chk("first_valid_latency", first_xfer_cyc, start_cyc + 3);
    chk("back_to_back", last_xfer_cyc - first_xfer_cyc, 5);
    chk("done_after_last_xfer", done_cyc, last_xfer_cyc + 1);

    // filter 2x2 with ready 1,0,0 pattern: stalls hold data, at most 2 buffered
    x0 = xfers;
    exp_sel = 2'd1; set_ready(1'b1);
    start_job(2'd1, 16'h0100, 2, 2, 16'h0020, 4'd3, 3'd0);
    wait_done(60, 1);
    chk("filter_word_count", xfers - x0, 4);

    // zero-length jobs: no reads, no valids, done right after the start edge
    r0 = ren_cnt;
    exp_sel = 2'd3; set_ready(1'b1);
    start_job(2'd0, 16'h0050, 3, 0, 16'd1, 4'd0, 3'd0);
    wait_done(6, 0);
    chk("zero_cols_done_cycle", done_cyc, start_cyc + 1);
    start_job(2'd3, 16'h0050, 2, 2, 16'd1, 4'd0, 3'd0);
    exp_sel = 2'd3;
    wait_done(6, 0);
    chk("reserved_sel_done_cycle", done_cyc, start_cyc + 1);
    chk("zero_len_no_reads", ren_cnt - r0, 0);

    // abort three cycles into a stalled 10-word ipsum job
    exp_sel = 2'd2; set_ready(1'b0);
    start_job(2'd2, 16'h0300, 2, 5, 16'h0010, 4'd0, 3'd1);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_valids_low", {GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid}, 0);
    chk("abort_ren_low", sram_ren, 0);
    drop_job();
    d0 = done_cnt;
    repeat (4) step();
    chk("abort_no_done", done_cnt, d0);
    exp_sel = 2'd0; set_ready(1'b1);
    start_job(2'd0, 16'h0040, 1, 3, 16'd0, 4'd5, 3'd1);
    wait_done(30, 0);

    // start while busy is ignored; the original 1x4 job completes
    x0 = xfers;
    exp_sel = 2'd0; set_ready(1'b1);
    start_job(2'd0, 16'h0200, 1, 4, 16'd0, 4'd2, 3'd0);
    step();
    stream_sel = 2'd1; base_addr = 16'h0300; num_cols = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(30, 0);
    chk("busy_start_word_count", xfers - x0, 4);

    // tag_X wrap
    obs_tx_q.delete();
    start_job(2'd0, 16'h0400, 1, 4, 16'd0, 4'd14, 3'd7);
    wait_done(30, 0);
    chk("wrap_count", obs_tx_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_tx_q.size(); i++) chk("wrap_tag_x", obs_tx_q[i], wrap_tx[i]);

    // counter boundaries with address wrap at 2^16
    x0 = xfers;
    exp_sel = 2'd1; set_ready(1'b1);
    start_job(2'd1, 16'hFFF0, 1, 255, 16'd0, 4'd0, 3'd0);
    wait_done(400, 0);
    start_job(2'd1, 16'hFF80, 255, 1, 16'd1, 4'd9, 3'd5);
    wait_done(400, 0);
    chk("max_count_words", xfers - x0, 510);

    // reset mid-job
    exp_sel = 2'd2; set_ready(1'b0);
    start_job(2'd2, 16'h0600, 2, 3, 16'd4, 4'd0, 3'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("midrst_busy_done", {busy, done}, 0);
    chk("midrst_valids", {GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid}, 0);
    chk("midrst_ren", sram_ren, 0);
    drop_job();
    d0 = done_cnt;
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
